// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared types and constants for the APB register-file slave
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    // Byte address to word index: the two low address bits select a byte.
    function automatic int word_idx_width(input int addr_w);
        return addr_w - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regfile_slave_if.sv
// ============================================================================
// apb_regfile_slave_if : APB bus bundle with master/slave views
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface apb_regfile_slave_if #(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 32
);
    logic [ADDRESSWIDTH-1:0] PADDR;
    logic [DATAWIDTH-1:0]    PWDATA;
    logic [DATAWIDTH/8-1:0]  PSTRB;
    logic                    PWRITE;
    logic                    PSELx;
    logic                    PENABLE;
    logic [DATAWIDTH-1:0]    PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PWDATA, PSTRB, PWRITE, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSTRB, PWRITE, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

`default_nettype wire

// File: rtl/apb_wait_counter.sv
// ============================================================================
// apb_wait_counter : loadable down-counter with zero flag for APB wait states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/apb_regfile_slave.sv
// ============================================================================
// apb_regfile_slave : APB slave with a read-only ID register, byte-strobed
//                     R/W registers and a configurable number of wait states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          ADDRESSWIDTH = 4,
    parameter int          DATAWIDTH    = 32,
    parameter int          NUM_REGS     = 4,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] ID_VALUE     = ID_VALUE_DEFAULT
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    apb_regfile_slave_if.slave            bus,
    output logic [NUM_REGS*DATAWIDTH-1:0] regs_o
);

    localparam int                   IW       = word_idx_width(ADDRESSWIDTH);
    localparam int                   NB       = DATAWIDTH / 8;
    localparam logic [DATAWIDTH-1:0] C_ID_VAL = DATAWIDTH'(ID_VALUE);
    localparam logic [3:0]           C_WAIT   = 4'(WAIT_CYCLES);
    localparam logic [0:0]           S_IDLE   = ST_IDLE;
    localparam logic [0:0]           S_ACCESS = ST_ACCESS;

    logic [0:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic                 r_write;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [NB-1:0]        r_strb;

    logic                 w_setup;
    logic                 w_access_en;
    logic                 w_cnt_zero;
    logic                 w_ready;
    logic                 w_err;
    logic                 w_commit;
    logic [DATAWIDTH-1:0] w_rd;
    logic                 w_unused_addr;

    assign w_unused_addr = ^bus.PADDR[1:0];

    assign w_setup     = (r_state == S_IDLE) && bus.PSELx && !bus.PENABLE;
    assign w_access_en = (r_state == S_ACCESS) && bus.PSELx && bus.PENABLE;
    // Gating with PRESETn keeps the bus quiet during the reset cycle itself.
    assign w_ready     = w_access_en && w_cnt_zero && PRESETn;
    assign w_err       = (r_write && (r_idx == '0)) || (32'(r_idx) >= NUM_REGS);
    assign w_commit    = w_ready && r_write && !w_err;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_setup) begin
                r_state <= S_ACCESS;
            end
        end else if (!bus.PSELx || w_ready) begin
            r_state <= S_IDLE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_setup) begin
            r_idx   <= bus.PADDR[ADDRESSWIDTH-1:2];
            r_write <= bus.PWRITE;
            r_wdata <= bus.PWDATA;
            r_strb  <= bus.PSTRB;
        end
    end

    apb_wait_counter #(
        .WIDTH (4)
    ) u_wait_counter (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (w_setup),
        .load_val (C_WAIT),
        .dec      (w_access_en && !w_cnt_zero),
        .zero     (w_cnt_zero)
    );

    assign regs_o[0 +: DATAWIDTH] = C_ID_VAL;

    genvar k;
    generate
        for (k = 1; k < NUM_REGS; k++) begin : g_reg
            logic [DATAWIDTH-1:0] r_reg;

            always_ff @(posedge PCLK) begin
                if (!PRESETn) begin
                    r_reg <= '0;
                end else if (w_commit && (r_idx == IW'(k))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_strb[b]) begin
                            r_reg[b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end
            end

            assign regs_o[k*DATAWIDTH +: DATAWIDTH] = r_reg;
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IW'(i)) begin
                w_rd = regs_o[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign bus.PREADY  = w_ready;
    assign bus.PSLVERR = w_ready && w_err;
    assign bus.PRDATA  = (w_ready && !w_err && !r_write) ? w_rd : '0;

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
// ============================================================================
// tb_apb_regfile_slave : directed vector bench for three slave configurations
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_apb_regfile_slave;

    typedef struct {
        int          dut;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_waits;
        int          chk_reg;
        logic [31:0] exp_reg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [127:0] regs0;
    logic [127:0] regs3;
    logic [95:0]  regsn;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_regfile_slave_if #(.ADDRESSWIDTH(4), .DATAWIDTH(32)) bus0 ();
    apb_regfile_slave_if #(.ADDRESSWIDTH(4), .DATAWIDTH(32)) bus3 ();
    apb_regfile_slave_if #(.ADDRESSWIDTH(4), .DATAWIDTH(32)) busn ();

    assign bus0.PSELx = sel[0];
    assign bus3.PSELx = sel[1];
    assign busn.PSELx = sel[2];
    assign {bus0.PENABLE, bus0.PWRITE, bus0.PADDR, bus0.PWDATA, bus0.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {bus3.PENABLE, bus3.PWRITE, bus3.PADDR, bus3.PWDATA, bus3.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {busn.PENABLE, busn.PWRITE, busn.PADDR, busn.PWDATA, busn.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};

    apb_regfile_slave #(.WAIT_CYCLES(0)) dut0 (.PCLK(clk), .PRESETn(rstn), .bus(bus0), .regs_o(regs0));
    apb_regfile_slave #(.WAIT_CYCLES(3)) dut3 (.PCLK(clk), .PRESETn(rstn), .bus(bus3), .regs_o(regs3));
    apb_regfile_slave #(.NUM_REGS(3))    dutn (.PCLK(clk), .PRESETn(rstn), .bus(busn), .regs_o(regsn));

    logic [2:0]  rdy_v;
    logic [2:0]  err_v;
    logic [31:0] rd_v [3];
    assign rdy_v = {busn.PREADY, bus3.PREADY, bus0.PREADY};
    assign err_v = {busn.PSLVERR, bus3.PSLVERR, bus0.PSLVERR};
    assign rd_v[0] = bus0.PRDATA;
    assign rd_v[1] = bus3.PRDATA;
    assign rd_v[2] = busn.PRDATA;

    function automatic logic [31:0] get_reg(input int d, input int k);
        case (d)
            0:       return regs0[k*32 +: 32];
            1:       return regs3[k*32 +: 32];
            default: return regsn[k*32 +: 32];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        sel     = 3'b000;
        penable = 1'b0;
    endtask

    // Live bus fields are scrambled during the access phase so that only
    // the values captured at setup can produce the expected result.
    task automatic xfer(input string tag, input vec_t v);
        int  waits;
        bit  done;
        @(negedge clk);
        sel         = 3'b000;
        sel[v.dut]  = 1'b1;
        penable     = 1'b0;
        pwrite      = v.wr;
        paddr       = v.addr;
        pwdata      = v.wdata;
        pstrb       = v.strb;
        @(negedge clk);
        penable = 1'b1;
        pwrite  = ~v.wr;
        paddr   = v.addr ^ 4'hC;
        pwdata  = ~v.wdata;
        pstrb   = ~v.strb;
        waits   = 0;
        done    = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (rdy_v[v.dut]) begin
                done = 1'b1;
            end else begin
                check({tag, " wait prdata"}, rd_v[v.dut], 32'h0);
                check({tag, " wait pslverr"}, 32'(err_v[v.dut]), 32'h0);
                waits++;
                @(negedge clk);
            end
        end
        check({tag, " completed"}, 32'(done), 32'h1);
        if (done) begin
            check({tag, " waits"}, waits, v.exp_waits);
            check({tag, " pslverr"}, 32'(err_v[v.dut]), 32'(v.exp_err));
            check({tag, " prdata"}, rd_v[v.dut], v.exp_rd);
            @(posedge clk);
            #1;
            if (v.chk_reg >= 0) begin
                check({tag, " reg"}, get_reg(v.dut, v.chk_reg), v.exp_reg);
            end
        end
    endtask

    vec_t vecs [15];
    vec_t tmp;

    initial begin
        vecs[0]  = '{0, 1'b1, 4'h4, 32'h0000000F, 4'hF, 32'h0,        1'b0, 0, 1, 32'h0000000F};
        vecs[1]  = '{0, 1'b0, 4'h0, 32'h0,        4'h0, 32'hA5B00001, 1'b0, 0, -1, 32'h0};
        vecs[2]  = '{0, 1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1, 0, 0, 32'hA5B00001};
        vecs[3]  = '{0, 1'b0, 4'h0, 32'h0,        4'h0, 32'hA5B00001, 1'b0, 0, -1, 32'h0};
        vecs[4]  = '{0, 1'b1, 4'h8, 32'h11223344, 4'hF, 32'h0,        1'b0, 0, 2, 32'h11223344};
        vecs[5]  = '{0, 1'b1, 4'h8, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0, 2, 32'h11BB33DD};
        vecs[6]  = '{0, 1'b0, 4'h8, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 0, -1, 32'h0};
        vecs[7]  = '{0, 1'b1, 4'hC, 32'hCAFEF00D, 4'hC, 32'h0,        1'b0, 0, 3, 32'hCAFE0000};
        vecs[8]  = '{0, 1'b0, 4'h4, 32'h0,        4'h0, 32'h0000000F, 1'b0, 0, -1, 32'h0};
        vecs[9]  = '{1, 1'b1, 4'h4, 32'h12345678, 4'hF, 32'h0,        1'b0, 3, 1, 32'h12345678};
        vecs[10] = '{1, 1'b0, 4'h4, 32'h0,        4'h0, 32'h12345678, 1'b0, 3, -1, 32'h0};
        vecs[11] = '{2, 1'b0, 4'hC, 32'h0,        4'h0, 32'h0,        1'b1, 0, -1, 32'h0};
        vecs[12] = '{2, 1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0, 2, 32'h0};
        vecs[13] = '{2, 1'b1, 4'h4, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0, 0, 1, 32'h5A5A5A5A};
        vecs[14] = '{2, 1'b0, 4'h4, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, 0, -1, 32'h0};

        rstn    = 1'b0;
        sel     = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 4'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset pready", 32'(bus0.PREADY), 32'h0);
        check("reset pslverr", 32'(bus0.PSLVERR), 32'h0);
        check("reset prdata", bus0.PRDATA, 32'h0);
        check("reset regs_o", regs0[127:96] | regs0[95:64] | regs0[63:32], 32'h0);
        check("reset id", regs0[31:0], 32'hA5B00001);
        @(negedge clk);
        rstn    = 1'b1;
        sel     = 3'b000;
        penable = 1'b0;

        for (int i = 0; i < 15; i++) begin
            xfer($sformatf("v%0d", i), vecs[i]);
        end
        go_idle();

        // Access phase without a setup phase must be ignored.
        @(negedge clk);
        sel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        #1;
        check("noset pready", 32'(bus0.PREADY), 32'h0);
        check("noset pslverr", 32'(bus0.PSLVERR), 32'h0);
        @(negedge clk);
        #1;
        check("noset pready2", 32'(bus0.PREADY), 32'h0);
        @(posedge clk);
        #1;
        check("noset reg1", get_reg(0, 1), 32'h0000000F);
        go_idle();

        // Drop select in the middle of the wait states.
        @(negedge clk);
        sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 4'h8; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("abort pready", 32'(bus3.PREADY), 32'h0);
        @(negedge clk);
        sel = 3'b000; penable = 1'b0;
        #1;
        check("abort pready2", 32'(bus3.PREADY), 32'h0);
        @(posedge clk);
        #1;
        check("abort reg2", get_reg(1, 2), 32'h0);
        tmp = '{1, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, 1'b0, 3, -1, 32'h0};
        xfer("abort rd", tmp);
        go_idle();

        // Reset in the middle of a wait-state transfer.
        @(negedge clk);
        sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rstmid pready", 32'(bus3.PREADY), 32'h0);
        check("rstmid pslverr", 32'(bus3.PSLVERR), 32'h0);
        check("rstmid prdata", bus3.PRDATA, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rstmid idle", 32'(bus3.PREADY), 32'h0);
        @(negedge clk);
        #1;
        check("rstmid idle2", 32'(bus3.PREADY), 32'h0);
        check("rstmid reg1", get_reg(1, 1), 32'h0);
        check("rstmid dut0 reg2", get_reg(0, 2), 32'h0);
        go_idle();
        tmp = '{1, 1'b0, 4'h4, 32'h0, 4'h0, 32'h0, 1'b0, 3, -1, 32'h0};
        xfer("rstmid rd", tmp);
        go_idle();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameter ADDRESSWIDTH, default 4: PADDR width in bits.
REQ-002 Parameter DATAWIDTH, default 32: data width; a multiple of 8.
REQ-003 Parameter NUM_REGS, default 4: register count, at most 2**(ADDRESSWIDTH-2).
REQ-004 Parameter WAIT_CYCLES, default 0: wait states inserted per transfer, 0..15.
REQ-005 Parameter ID_VALUE, default 32'hA5B0_0001: constant value returned by read-only register 0.
REQ-006 PCLK  in  1  clock; all logic on the rising edge.
REQ-007 PRESETn  in  1  reset; synchronous, active-low.
REQ-008 PADDR  in  ADDRESSWIDTH  byte address; word index = PADDR[ADDRESSWIDTH-1:2].
REQ-009 PWDATA  in  DATAWIDTH  write data.
REQ-010 PSTRB  in  DATAWIDTH/8  byte write strobes.
REQ-011 PWRITE  in  1  1 = write, 0 = read.
REQ-012 PSELx  in  1  slave select.
REQ-013 PENABLE  in  1  access phase.
REQ-014 PRDATA  out  DATAWIDTH  read data.
REQ-015 PREADY  out  1  transfer completes this cycle.
REQ-016 PSLVERR  out  1  error response; valid only when PREADY=1.
REQ-017 regs_o  out  NUM_REGS*DATAWIDTH  flat register contents; register k occupies bits [k*DATAWIDTH +: DATAWIDTH].

Function
REQ-018 The FSM SHALL have two states: IDLE and ACCESS.
REQ-019 IDLE -> ACCESS when PSELx=1 and PENABLE=0; on this edge, wait counter := WAIT_CYCLES and PADDR, PWRITE, PWDATA, PSTRB are captured.
REQ-020 PSELx=1 and PENABLE=1 in IDLE is a protocol violation; the block SHALL ignore it, stay in IDLE and keep PREADY=0.
REQ-021 In ACCESS with PSELx=1, PENABLE=1 and counter>0: decrement the counter and hold PREADY=0.
REQ-022 PREADY SHALL be 1 only in ACCESS with counter=0, PSELx=1 and PENABLE=1; a transfer takes 2+WAIT_CYCLES cycles.
REQ-023 On the completing cycle, the FSM SHALL return to IDLE; a new setup phase in the following cycle SHALL be accepted (back-to-back).
REQ-024 PSELx=0 while in ACCESS SHALL abort the transfer to IDLE with no register update and no PREADY.
REQ-025 A write SHALL commit at the completing edge: byte b of the register updates only if PSTRB[b]=1.
REQ-026 A read SHALL drive PRDATA = the addressed register during the PREADY=1 cycle; at all other times PRDATA = 0.
REQ-027 Register 0 SHALL read ID_VALUE (truncated or zero-extended to DATAWIDTH).
REQ-028 A write to register 0, or any access with word index >= NUM_REGS, SHALL give PSLVERR=1 and PRDATA=0 on the completing cycle, with no state change.
REQ-029 PSLVERR SHALL be 0 whenever PREADY=0.
REQ-030 Decode and error checks SHALL use the captured address and control, not live PADDR.

Reset
REQ-031 With PRESETn=0 at a rising edge: state := IDLE, counter := 0, registers 1..NUM_REGS-1 := 0.
REQ-032 During reset, PREADY=0, PSLVERR=0 and PRDATA=0; reset mid-transfer SHALL discard the transfer.

Structure
REQ-033 Package apb_pkg SHALL hold the state enum, the ID_VALUE default and the word-index width function.
REQ-034 One sub-module, apb_wait_counter (load, decrement, zero flag), SHALL implement the wait counter.

Verification
REQ-035 Reset, then WAIT_CYCLES=0, write 0x0000000F to address 4 with PSTRB=4'hF -> PREADY=1 in the second cycle, PSLVERR=0, regs_o[63:32]=0x0000000F.
REQ-036 Read address 0 -> PRDATA=0xA5B00001, PSLVERR=0; write address 0 -> PSLVERR=1, readback unchanged.
REQ-037 WAIT_CYCLES=3, read address 4 -> PREADY low for 3 access cycles and high on the 4th, with PRDATA valid only then.
REQ-038 Register 2 = 0x11223344, write 0xAABBCCDD to address 8 with PSTRB=4'b0101 -> register 2 = 0x11BB33DD.
REQ-039 NUM_REGS=3, access address 12 -> PSLVERR=1, PRDATA=0; back-to-back write then read of address 4 -> both complete, read returns the written data.
REQ-040 Drop PSELx mid-wait, or assert PRESETn=0 mid-transfer -> no register update, FSM in IDLE, PREADY=0.
